countdown_24: RTL and testbench

Loadable 24-bit down-counter/timer built from three cascaded 8-bit down-count stages with borrow propagation. It is the decrementing counterpart of the team's cascaded up-counter. Software or a sequencer loads a start value, starts it, and receives a one-cycle `done` pulse when the count reaches zero. It sits beside the up-counter in the timing/counter subsystem and is used for timeouts and interval generation.

---
 rtl/counter_pkg.sv | 13 +
 rtl/countdown_24_down_stage.sv | 26 ++
 rtl/countdown_24.sv | 133 +++++++++++++
 tb/tb_countdown_24.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded up/down counters: FSM state type and widths.
package counter_pkg;

   localparam int COUNT_W = 24;
   localparam int STAGE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cnt_state_t;

endpackage

// File: rtl/countdown_24_down_stage.sv
// One STAGE_W-bit down-count stage; wraps from 0 to all-ones when decremented.
module down_stage #(
   parameter int STAGE_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [STAGE_W-1:0] load_val,
   input  logic               dec,
   output logic [STAGE_W-1:0] q,
   output logic               is_zero
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (dec) begin
         q <= q - 1'b1;
      end
   end

   assign is_zero = (q == '0);

endmodule

// File: rtl/countdown_24.sv
// Loadable 24-bit down-counter built from cascaded down_stage instances.
// Define COUNTDOWN_AUTO_RELOAD_EN to make the terminal decrement reload and keep running.
//
// state | meaning
// IDLE  | waiting; load/start accepted, count held
// RUN   | decrementing on en, busy high
// DONE  | one cycle after terminal decrement, done high
module countdown_24 #(
   parameter int W       = counter_pkg::COUNT_W,
   parameter int STAGE_W = counter_pkg::STAGE_W,
   parameter int STAGES  = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         start,
   input  logic         stop,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         busy,
   output logic         done,
   output logic         zero
);

   import counter_pkg::*;

   cnt_state_t state, state_nxt;

   logic [W-1:0]      reload;
   logic [W-1:0]      stage_load_val;
   logic [STAGES-1:0] stage_zero;
   logic [STAGES-1:0] borrow;
   logic              load_acc;
   logic              reload_now;
   logic              dec_en;
   logic              done_nxt;
   logic              count_is_one;

   assign count_is_one = (count == W'(1));
   assign zero         = &stage_zero;
   assign busy         = (state == RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         done   <= 1'b0;
         reload <= '0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
         if (load_acc) begin
            reload <= load_val;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      done_nxt   = 1'b0;
      load_acc   = 1'b0;
      reload_now = 1'b0;
      dec_en     = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               load_acc = 1'b1;
            end else if (start) begin
               if (!zero) begin
                  state_nxt = RUN;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (en && !zero) begin
               if (count_is_one) begin
                  done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  if (reload != '0) begin
                     reload_now = 1'b1;
                  end else begin
                     dec_en    = 1'b1;
                     state_nxt = DONE;
                  end
`else
                  dec_en    = 1'b1;
                  state_nxt = DONE;
`endif
               end else begin
                  dec_en = 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
            if (load) begin
               load_acc = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // A reload replaces the decrement, so the stages only ever see one of load/dec.
   assign stage_load_val = reload_now ? reload : load_val;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign borrow[k] = dec_en;
      end else begin : g_rest
         assign borrow[k] = borrow[k-1] & stage_zero[k-1];
      end

      down_stage #(
         .STAGE_W (STAGE_W)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .load     (load_acc | reload_now),
         .load_val (stage_load_val[k*STAGE_W +: STAGE_W]),
         .dec      (borrow[k]),
         .q        (count[k*STAGE_W +: STAGE_W]),
         .is_zero  (stage_zero[k])
      );
   end

endmodule

// File: tb/tb_countdown_24.sv
// Randomized and directed checks of countdown_24 against a plain-arithmetic timer model.
module tb_countdown_24;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [23:0] load_val;
   logic        start;
   logic        stop;
   logic        en;
   logic [23:0] count;
   logic        busy;
   logic        done;
   logic        zero;

   int total = 0;
   int bad   = 0;

   // model: running timer, one-cycle "finished" flag, value, reload, done pulse
   bit          m_run;
   bit          m_fin;
   int unsigned m_cnt;
   int unsigned m_rel;
   bit          m_done;

   countdown_24 dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .stop     (stop),
      .en       (en),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run  = 0;
      m_fin  = 0;
      m_cnt  = 0;
      m_rel  = 0;
      m_done = 0;
   endtask

   task automatic model_edge();
      bit nd;
      nd = 0;
      if (reset) begin
         model_reset();
         return;
      end
      if (m_run) begin
         if (stop) begin
            m_run = 0;
         end else if (en && m_cnt != 0) begin
            if (m_cnt == 1) begin
               nd = 1;
               if (AUTO && m_rel != 0) begin
                  m_cnt = m_rel;
               end else begin
                  m_cnt = 0;
                  m_run = 0;
                  m_fin = 1;
               end
            end else begin
               m_cnt = m_cnt - 1;
            end
         end
      end else begin
         bit was_fin;
         was_fin = m_fin;
         m_fin   = 0;
         if (load) begin
            m_cnt = 32'(load_val);
            m_rel = 32'(load_val);
         end else if (start && !was_fin) begin
            if (m_cnt != 0) m_run = 1;
            else            nd = 1;
         end
      end
      m_done = nd;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("count", {8'h0, count}, m_cnt);
      chk("busy",  {31'h0, busy}, {31'h0, m_run});
      chk("done",  {31'h0, done}, {31'h0, m_done});
      chk("zero",  {31'h0, zero}, {31'h0, (m_cnt == 0)});
   endtask

   task automatic quiet();
      load  = 0;
      start = 0;
      stop  = 0;
      en    = 0;
   endtask

   task automatic do_load(input logic [23:0] v);
      quiet();
      load     = 1;
      load_val = v;
      tick();
      load = 0;
   endtask

   task automatic do_start();
      quiet();
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic do_stop();
      quiet();
      stop = 1;
      tick();
      stop = 0;
   endtask

   initial begin
      int n_busy;
      int n_done;
      int done_at;
      quiet();
      load_val = '0;
      reset    = 1;
      model_reset();
      #12;
      chk("rst_count", {8'h0, count}, 32'h0);
      chk("rst_busy",  {31'h0, busy}, 32'h0);
      chk("rst_done",  {31'h0, done}, 32'h0);
      @(negedge clk);
      reset = 0;
      tick();

      // load 5, run to completion
      do_load(24'd5);
      do_start();
      n_busy  = busy ? 1 : 0;
      done_at = 0;
      en = 1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (busy) n_busy++;
         if (done && done_at == 0) done_at = i;
      end
      en = 0;
      if (!AUTO) begin
         chk("busy_cycles", n_busy, 5);
         chk("done_cycle", done_at, 5);
      end
      do_stop();

      // borrow across stages
      do_load(24'h010000);
      do_start();
      en = 1;
      tick();
      en = 0;
      chk("borrow_16", {8'h0, count}, 32'h00FFFF);
      do_stop();
      do_load(24'h000100);
      do_start();
      en = 1;
      tick();
      en = 0;
      chk("borrow_8", {8'h0, count}, 32'h0000FF);
      do_stop();

      // en toggling: ten decrements take twenty cycles
      do_load(24'd10);
      do_start();
      done_at = 0;
      for (int i = 1; i <= 24; i++) begin
         en = (i % 2 == 0);
         tick();
         if (done && done_at == 0) done_at = i;
      end
      chk("toggle_done", done_at, 20);
      do_stop();

      // stop beats en
      do_load(24'd10);
      do_start();
      en = 1;
      for (int i = 0; i < 6; i++) tick();
      stop = 1;
      tick();
      chk("stop_count", {8'h0, count}, 32'd4);
      chk("stop_busy", {31'h0, busy}, 32'h0);
      quiet();
      en = 1;
      tick();
      chk("stop_held", {8'h0, count}, 32'd4);
      en = 0;

      // load wins over start
      quiet();
      load = 1; start = 1; load_val = 24'd7;
      tick();
      chk("ldst_busy", {31'h0, busy}, 32'h0);
      chk("ldst_count", {8'h0, count}, 32'd7);

      // start with zero count
      do_load(24'd0);
      do_start();
      chk("zstart_done", {31'h0, done}, 32'h1);
      chk("zstart_busy", {31'h0, busy}, 32'h0);
      quiet();
      tick();
      chk("zstart_pulse", {31'h0, done}, 32'h0);

      // load ignored while running
      do_load(24'd8);
      do_start();
      quiet();
      load = 1; load_val = 24'd3;
      tick();
      load = 0;
      chk("run_load", {8'h0, count}, 32'd8);
      do_stop();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
      do_load(24'd3);
      do_start();
      en = 1;
      n_busy = 0;
      n_done = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (busy) n_busy++;
         if (done) n_done++;
      end
      en = 0;
      chk("auto_pulses", n_done, 3);
      chk("auto_busy", n_busy, 9);
      do_stop();
`endif

      // asynchronous reset mid-run
      do_load(24'h000100);
      do_start();
      en = 0;
      tick();
      #3;
      reset = 1;
      #1;
      chk("mrst_count", {8'h0, count}, 32'h0);
      chk("mrst_busy", {31'h0, busy}, 32'h0);
      chk("mrst_done", {31'h0, done}, 32'h0);
      model_reset();
      tick();
      reset = 0;
      tick();

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         load  = ($urandom % 6 == 0);
         start = ($urandom % 3 == 0);
         stop  = ($urandom % 40 == 0);
         en    = ($urandom % 10 < 7);
         case ($urandom % 8)
            0:       load_val = 24'h0;
            1:       load_val = 24'h010000;
            2:       load_val = 24'h000100;
            3:       load_val = 24'($urandom);
            default: load_val = 24'($urandom_range(1, 12));
         endcase
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
